ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Parametrised RV32M/RV64M execute unit for the EX stage of the 5-stage RISC-V pipeline.
- Replaces the single-cycle 32-bit low-half multiply with full M-extension support: MUL/MULH/MULHSU/MULHU with configurable latency, and DIV/DIVU/REM/REMU on an iterative radix-2 divider.
- Uses valid/ready handshakes toward ID and MEM.
- Takes a flush input so a branch mispredict can kill an in-flight op.

Parameters:
- XLEN, 32, operand/result width; legal values are 32 or 64.
- TAG_W, 5, width of the opaque tag (destination register number) carried with each op.
- MUL_LAT, 2, accept-to-out_valid latency for multiply ops in cycles; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill any in-flight or completed-but-unconsumed op
- in_valid  in  1  op offered by ID
- in_ready  out  1  unit can accept an op this cycle
- in_op  in  3  RISC-V funct3 of an M-extension op
- in_a  in  XLEN  rs1 operand
- in_b  in  XLEN  rs2 operand
- in_tag  in  TAG_W  tag carried with the op
- out_valid  out  1  result available to MEM
- out_ready  in  1  MEM consumes the result
- out_result  out  XLEN  result
- out_tag  out  TAG_W  tag of the op in out_result
- busy  out  1  state is not IDLE (used by the ID hazard logic)

Behaviour:
- Reset values: state=IDLE; out_valid=0; out_result=0; out_tag=0; busy=0; all internal registers cleared.
- Accept: an op is accepted when in_valid && in_ready at a rising edge (edge k).
- in_ready = ~flush && (state==IDLE || (state==DONE && out_ready)). This allows back-to-back issue with no bubble.
- Accept captures in_op, in_a, in_b and in_tag. The tag is held unchanged until the result is consumed.
- States: IDLE, MUL, DIV, DONE.
  - out_valid = (state==DONE).
  - out_result and out_tag are stable while out_valid && ~out_ready.
- Multiply path:
  - MUL_LAT==1: accept goes straight to DONE.
  - MUL_LAT>1: accept goes to MUL with count=MUL_LAT-1, decrementing each edge; DONE when count reaches 1 → 0.
  - out_valid is first high after edge k+MUL_LAT-1, i.e. MUL_LAT cycles including the accept cycle.
  - Product is 2*XLEN bits. MUL returns the low XLEN bits.
  - MULH: signed×signed, high half. MULHSU: signed×unsigned, high half. MULHU: unsigned×unsigned, high half.
- Divide path:
  - Operands are converted to magnitudes at accept; quotient and remainder signs are recorded.
  - Special cases go straight to DONE at edge k:
    - Divide by zero: quotient = all ones; remainder = in_a.
    - Signed overflow (a = -2^(XLEN-1), b = -1): quotient = a; remainder = 0.
  - Otherwise: DIV state with count=XLEN; one restoring-division step per edge producing one quotient bit MSB-first.
  - After the XLEN-th step the unit moves to DONE; out_valid is first high after edge k+XLEN.
  - Sign correction is applied in the final step:
    - DIV: quotient negated iff sign(a) != sign(b).
    - REM: remainder takes the sign of a.
  - DIVU/REMU are unsigned with no sign correction.
- DONE: on out_ready, go to IDLE, or reload directly into MUL/DIV/DONE if a new op is accepted on the same edge.
- Flush (highest priority after rst):
  - At the next edge the state becomes IDLE and out_valid drops.
  - The result is discarded even if out_ready was high in the same cycle; MEM must ignore out_valid when flush=1.
  - No op is accepted in a flush cycle.
- Reset mid-operation: same as flush, and additionally all datapath registers are cleared.
- busy = (state != IDLE).

Decomposition:
- Shared package ex_muldiv_pkg holds:
  - funct3 encodings: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - The state enum {IDLE, MUL, DIV, DONE}.
  - An is_div(op) helper, i.e. op[2].
- One sub-module, div_iter, contains the XLEN-step restoring divider: start/step/done interface, remainder and quotient shift registers, and its own counter.
- The multiply stays in the top module as an operand-register product followed by (MUL_LAT-1) result registers, so that synthesis can retime it.

Test Plan:
- XLEN=32, MUL_LAT=2, MULHU a=0xFFFFFFFF b=0xFFFFFFFF tag=7, out_ready=1 → out_valid in the 2nd cycle after accept, result 0xFFFFFFFE, tag 7.
- MULH a=0x80000000 b=0x80000000 → 0x40000000; MULHSU a=0xFFFFFFFF b=0xFFFFFFFF → 0xFFFFFFFF; MUL a=7 b=-3 → 0xFFFFFFEB.
- DIV a=-7 b=2 → out_valid exactly 32 cycles after the accept edge, result 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; REMU a=100 b=7 → 2.
- DIVU a=5 b=0 → 0xFFFFFFFF after 1 cycle; REM a=5 b=0 → 5; DIV a=0x80000000 b=0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Hold out_ready=0 for 5 cycles in DONE → out_result/out_tag stable and in_ready=0; then issue a new MUL on the same edge as out_ready=1 → no bubble, next result after MUL_LAT.
- Assert flush at DIV step 10 → IDLE next cycle, out_valid never rises for the killed op, and a new op accepted the following cycle completes correctly. Repeat with rst in place of flush → all outputs 0.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and helpers for the EX-stage RV32M/RV64M multiply/divide unit.
package ex_muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes: one quotient bit per step, MSB first.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quo_next,
    output logic [XLEN-1:0] rem_next
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_START = CW'(XLEN);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] dsr_r;
    logic [CW-1:0]   cnt_r;
    logic [XLEN:0]   rem_shift_s;
    logic [XLEN:0]   diff_s;

    // done flags the step that produces the last quotient bit; outputs are that step's results
    assign done        = (cnt_r == CNT_ONE);
    assign rem_shift_s = {rem_r, quo_r[XLEN-1]};
    assign diff_s      = rem_shift_s - {1'b0, dsr_r};

    // Trial subtraction: keep the difference when it did not borrow
    always_comb begin
        rem_next = rem_shift_s[XLEN-1:0];
        quo_next = {quo_r[XLEN-2:0], 1'b0};
        if (!diff_s[XLEN]) begin
            rem_next = diff_s[XLEN-1:0];
            quo_next = {quo_r[XLEN-2:0], 1'b1};
        end else begin
            rem_next = rem_shift_s[XLEN-1:0];
            quo_next = {quo_r[XLEN-2:0], 1'b0};
        end
    end

    // Dividend shifts out of quo_r while quotient bits shift in
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_r <= {XLEN{1'b0}};
            rem_r <= {XLEN{1'b0}};
            dsr_r <= {XLEN{1'b0}};
            cnt_r <= CNT_ZERO;
        end else if (start) begin
            quo_r <= dividend;
            rem_r <= {XLEN{1'b0}};
            dsr_r <= divisor;
            cnt_r <= CNT_START;
        end else if (step && (cnt_r != CNT_ZERO)) begin
            quo_r <= quo_next;
            rem_r <= rem_next;
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage M-extension unit: pipelined multiply plus iterative divide behind valid/ready.
module ex_muldiv_unit
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 5,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(MUL_LAT) + 2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  X_ZERO   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  X_ONES   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  X_MIN    = {1'b1, {(XLEN-1){1'b0}}};

    state_e           state_r;
    logic [2:0]       op_r;
    logic [XLEN-1:0]  a_r;
    logic [XLEN-1:0]  b_r;
    logic [TAG_W-1:0] tag_r;
    logic [XLEN-1:0]  div_res_r;
    logic             q_neg_r;
    logic             r_neg_r;
    logic [CNT_W-1:0] mul_cnt_r;

    logic             accept_s;
    logic             div_signed_s;
    logic             neg_a_s;
    logic             neg_b_s;
    logic [XLEN-1:0]  mag_a_s;
    logic [XLEN-1:0]  mag_b_s;
    logic             div_zero_s;
    logic             div_ovf_s;
    logic             div_done_s;
    logic [XLEN-1:0]  div_quo_s;
    logic [XLEN-1:0]  div_rem_s;
    logic [XLEN-1:0]  div_fin_s;
    logic             ma_sign_s;
    logic             mb_sign_s;
    logic [2*XLEN-1:0] ma_s;
    logic [2*XLEN-1:0] mb_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]  mul_sel_s;
    logic [XLEN-1:0]  mul_res_s;

    assign in_ready  = ~flush && ((state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready));
    assign accept_s  = in_valid && in_ready;
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r != ST_IDLE);
    assign out_tag   = tag_r;
    assign out_result = is_div(op_r) ? div_res_r : mul_res_s;

    // Divide operand preparation at accept
    assign div_signed_s = ~in_op[0];
    assign neg_a_s      = div_signed_s & in_a[XLEN-1];
    assign neg_b_s      = div_signed_s & in_b[XLEN-1];
    assign mag_a_s      = neg_a_s ? -in_a : in_a;
    assign mag_b_s      = neg_b_s ? -in_b : in_b;
    assign div_zero_s   = (in_b == X_ZERO);
    assign div_ovf_s    = div_signed_s && (in_a == X_MIN) && (in_b == X_ONES);

    div_iter #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (accept_s && is_div(in_op)),
        .step     (state_r == ST_DIV),
        .dividend (mag_a_s),
        .divisor  (mag_b_s),
        .done     (div_done_s),
        .quo_next (div_quo_s),
        .rem_next (div_rem_s)
    );

    assign div_fin_s = op_r[1] ? (r_neg_r ? -div_rem_s : div_rem_s)
                               : (q_neg_r ? -div_quo_s : div_quo_s);

    // Sign-extend into a double-width product; the low 2*XLEN bits are exact for any signedness
    assign ma_sign_s = ((op_r == F3_MULH) || (op_r == F3_MULHSU)) & a_r[XLEN-1];
    assign mb_sign_s = (op_r == F3_MULH) & b_r[XLEN-1];
    assign ma_s      = {{XLEN{ma_sign_s}}, a_r};
    assign mb_s      = {{XLEN{mb_sign_s}}, b_r};
    assign prod_s    = ma_s * mb_s;
    assign mul_sel_s = (op_r == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

    generate
        if (MUL_LAT == 1) begin : g_mul_comb
            assign mul_res_s = mul_sel_s;
        end else begin : g_mul_pipe
            logic [XLEN-1:0] pipe_r [MUL_LAT-1];

            // Free-running result registers behind the product for retiming
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < MUL_LAT - 1; i++) begin
                        pipe_r[i] <= {XLEN{1'b0}};
                    end
                end else begin
                    pipe_r[0] <= mul_sel_s;
                    for (int i = 1; i < MUL_LAT - 1; i++) begin
                        pipe_r[i] <= pipe_r[i-1];
                    end
                end
            end

            assign mul_res_s = pipe_r[MUL_LAT-2];
        end
    endgenerate

    // Control FSM and operand/result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            op_r      <= 3'b000;
            a_r       <= X_ZERO;
            b_r       <= X_ZERO;
            tag_r     <= {TAG_W{1'b0}};
            div_res_r <= X_ZERO;
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            mul_cnt_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            state_r <= ST_IDLE;
        end else if (accept_s) begin
            op_r    <= in_op;
            a_r     <= in_a;
            b_r     <= in_b;
            tag_r   <= in_tag;
            q_neg_r <= neg_a_s ^ neg_b_s;
            r_neg_r <= neg_a_s;
            if (is_div(in_op)) begin
                if (div_zero_s) begin
                    div_res_r <= in_op[1] ? in_a : X_ONES;
                    state_r   <= ST_DONE;
                end else if (div_ovf_s) begin
                    div_res_r <= in_op[1] ? X_ZERO : in_a;
                    state_r   <= ST_DONE;
                end else begin
                    state_r <= ST_DIV;
                end
            end else if (MUL_LAT == 1) begin
                state_r <= ST_DONE;
            end else begin
                state_r   <= ST_MUL;
                mul_cnt_r <= CNT_INIT;
            end
        end else begin
            case (state_r)
                ST_IDLE: state_r <= ST_IDLE;
                ST_MUL: begin
                    mul_cnt_r <= mul_cnt_r - CNT_ONE;
                    if (mul_cnt_r == CNT_ONE) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_MUL;
                    end
                end
                ST_DIV: begin
                    if (div_done_s) begin
                        state_r   <= ST_DONE;
                        div_res_r <= div_fin_s;
                    end else begin
                        state_r <= ST_DIV;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit at XLEN=32, MUL_LAT=2.
module tb_ex_muldiv_unit;

    localparam int XLEN    = 32;
    localparam int TAG_W   = 5;
    localparam int MUL_LAT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    typedef struct {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic [31:0] r;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        ia = int'(a);
        ib = int'(b);
        p  = 64'h0;
        r  = 32'h0;
        case (op)
            3'b000: begin p = sa * sb; r = p[31:0]; end
            3'b001: begin p = sa * sb; r = p[63:32]; end
            3'b010: begin p = sa * ub; r = p[63:32]; end
            3'b011: begin p = ua * ub; r = p[63:32]; end
            3'b100: r = (b == 32'h0) ? 32'hFFFFFFFF :
                        (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(ia / ib);
            3'b101: r = (b == 32'h0) ? 32'hFFFFFFFF : a / b;
            3'b110: r = (b == 32'h0) ? a :
                        (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(ia % ib);
            default: r = (b == 32'h0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return MUL_LAT - 1;
        if (b == 32'h0) return 0;
        if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
        return XLEN;
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp_res, input int exp_lat);
        exp_t e;
        int n;
        e.res = exp_res;
        e.tag = tag;
        sb_q.push_back(e);
        in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready op=%0d: got %b expected 1", op, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb_q.pop_front();
        checks++;
        if (n != exp_lat) begin
            errors++;
            $display("FAIL latency op=%0d a=%h b=%h: got %0d expected %0d", op, a, b, n, exp_lat);
        end
        checks++;
        if (out_result !== e.res) begin
            errors++;
            $display("FAIL result op=%0d a=%h b=%h: got %h expected %h", op, a, b, out_result, e.res);
        end
        checks++;
        if (out_tag !== e.tag) begin
            errors++;
            $display("FAIL tag op=%0d: got %0d expected %0d", op, out_tag, e.tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 3'b000; in_a = 32'h0; in_b = 32'h0; in_tag = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 32'h0 || out_tag !== 5'd0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b busy=%b res=%h tag=%0d expected all 0",
                     out_valid, busy, out_result, out_tag);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_mul();
        do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE, 1);
        do_op(3'b001, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000, 1);
        do_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFF, 1);
        do_op(3'b000, 32'd7,        32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB, 1);
    endtask

    task automatic test_div();
        do_op(3'b100, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 32);
        do_op(3'b110, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFF, 32);
        do_op(3'b111, 32'd100,      32'd7,        5'd6,  32'd2,        32);
        do_op(3'b101, 32'd5,        32'd0,        5'd8,  32'hFFFFFFFF, 0);
        do_op(3'b110, 32'd5,        32'd0,        5'd9,  32'd5,        0);
        do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 0);
        do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0,        0);
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        int sel;
        for (int i = 0; i < 16; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            sel = $urandom_range(0, 5);
            b   = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFFFFFF : $urandom;
            if (sel == 2) a = 32'h80000000;
            do_op(op, a, b, 5'(i + 12), model_res(op, a, b), model_lat(op, a, b));
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int n;
        e.res = 32'd15; e.tag = 5'd3;
        sb_q.push_back(e);
        in_op = 3'b000; in_a = 32'd3; in_b = 32'd5; in_tag = 5'd3; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb_q.pop_front();
        checks++;
        if (out_result !== e.res || out_tag !== e.tag) begin
            errors++;
            $display("FAIL stall_first: got %h/%0d expected %h/%0d", out_result, out_tag, e.res, e.tag);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_result !== e.res || out_tag !== e.tag || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got v=%b res=%h tag=%0d rdy=%b expected v=1 res=%h tag=%0d rdy=0",
                         i, out_valid, out_result, out_tag, in_ready, e.res, e.tag);
            end
        end
        e.res = 32'd1; e.tag = 5'd4;
        sb_q.push_back(e);
        in_op = 3'b011; in_a = 32'h00010000; in_b = 32'h00010000; in_tag = 5'd4;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_inflight: got v=%b busy=%b expected v=0 busy=1", out_valid, busy);
        end
        @(posedge clk); #1;
        e = sb_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_result !== e.res || out_tag !== e.tag) begin
            errors++;
            $display("FAIL b2b_result: got v=%b %h/%0d expected v=1 %h/%0d", out_valid, out_result, out_tag, e.res, e.tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_kill(input bit use_rst);
        in_op = 3'b101; in_a = 32'd1000; in_b = 32'd3; in_tag = 5'd9; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        in_op = 3'b000; in_a = 32'd2; in_b = 32'd2; in_tag = 5'd1; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL kill_ready rst=%0d: got %b expected 0", use_rst, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle rst=%0d: got busy=%b v=%b expected 0 0", use_rst, busy, out_valid);
        end
        if (use_rst) begin
            checks++;
            if (out_result !== 32'h0 || out_tag !== 5'd0) begin
                errors++;
                $display("FAIL kill_rst_outputs: got %h/%0d expected 0/0", out_result, out_tag);
            end
        end
        do_op(3'b101, 32'd1000, 32'd3, 5'd10, 32'd333, 32);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_random();
        test_back_to_back();
        test_kill(1'b0);
        test_kill(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
